ddr2_rd_data_chk_16: RTL and testbench

Read-data checker for the 16-bit DDR2 test backend. It consumes read words returned by the controller's read-data FIFO path and regenerates, per valid beat, the same four-beat pattern sequence the write-data generator produces. It compares each word against the expected value and reports per-beat mismatches, a sticky error flag, a saturating error count, first-error capture and per-burst pass pulses. It sits beside the write-data generator in the backend test harness and replaces ad-hoc comparison against `app_compare_data`.

---
 rtl/ddr2_rd_data_chk_16.sv | 111 +++++++++++
 tb/tb_ddr2_rd_data_chk_16.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/ddr2_rd_data_chk_16.sv
// rtl/ddr2_rd_data_chk_16.sv - read-data checker for the 16-bit DDR2 test backend
// Regenerates the four-beat write pattern per valid beat and reports mismatches, counts and first error.
module ddr2_rd_data_chk_16 #(
  parameter int ERR_CNT_W = 16
) (
  input  logic                 clk0,
  input  logic                 rst_n,
  input  logic                 rd_data_valid,
  input  logic [31:0]          rd_data,
  input  logic                 clr_err,
  output logic                 err_pulse,
  output logic                 err_sticky,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic [31:0]          first_err_data,
  output logic [1:0]           first_err_beat,
  output logic                 burst_ok,
  output logic [1:0]           beat_idx
);

  logic [1:0]           beat_idx_q, beat_idx_d;
  logic                 err_pulse_q, err_pulse_d;
  logic                 burst_ok_q, burst_ok_d;
  logic                 err_sticky_q, err_sticky_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [31:0]          first_err_data_q, first_err_data_d;
  logic [1:0]           first_err_beat_q, first_err_beat_d;
  logic                 burst_bad_q, burst_bad_d;

  logic [15:0]          exp_pat;
  logic [31:0]          exp_word;
  logic                 mismatch;
  logic                 sticky_base;
  logic                 burst_bad_base;
  logic [ERR_CNT_W-1:0] cnt_base;

  always_comb begin
    exp_pat = 16'hFFFF;
    case (beat_idx_q)
      2'd0: exp_pat = 16'hFFFF;
      2'd1: exp_pat = 16'hAAAA;
      2'd2: exp_pat = 16'h5555;
      2'd3: exp_pat = 16'h9999;
      default: exp_pat = 16'hFFFF;
    endcase
    exp_word = {exp_pat, ~exp_pat};
    mismatch = rd_data_valid && (rd_data != exp_word);

    // A clear takes effect first, so a mismatch in the same cycle lands on cleared state
    sticky_base    = clr_err ? 1'b0 : err_sticky_q;
    burst_bad_base = clr_err ? 1'b0 : burst_bad_q;
    cnt_base       = clr_err ? '0 : err_cnt_q;

    beat_idx_d       = rd_data_valid ? beat_idx_q + 2'd1 : beat_idx_q;
    err_pulse_d      = mismatch;
    burst_ok_d       = rd_data_valid && (beat_idx_q == 2'd3) && !mismatch && !burst_bad_base;
    err_sticky_d     = sticky_base || mismatch;
    err_cnt_d        = cnt_base;
    first_err_data_d = clr_err ? 32'h0 : first_err_data_q;
    first_err_beat_d = clr_err ? 2'd0 : first_err_beat_q;
    burst_bad_d      = burst_bad_base;

    if (mismatch) begin
      if (cnt_base != '1) begin
        err_cnt_d = cnt_base + ERR_CNT_W'(1);
      end
      if (!sticky_base) begin
        first_err_data_d = rd_data;
        first_err_beat_d = beat_idx_q;
      end
    end

    if (rd_data_valid) begin
      if (beat_idx_q == 2'd3) begin
        burst_bad_d = 1'b0;
      end else if (mismatch) begin
        burst_bad_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk0 or negedge rst_n) begin
    if (!rst_n) begin
      beat_idx_q       <= 2'd0;
      err_pulse_q      <= 1'b0;
      burst_ok_q       <= 1'b0;
      err_sticky_q     <= 1'b0;
      err_cnt_q        <= '0;
      first_err_data_q <= 32'h0;
      first_err_beat_q <= 2'd0;
      burst_bad_q      <= 1'b0;
    end else begin
      beat_idx_q       <= beat_idx_d;
      err_pulse_q      <= err_pulse_d;
      burst_ok_q       <= burst_ok_d;
      err_sticky_q     <= err_sticky_d;
      err_cnt_q        <= err_cnt_d;
      first_err_data_q <= first_err_data_d;
      first_err_beat_q <= first_err_beat_d;
      burst_bad_q      <= burst_bad_d;
    end
  end

  assign err_pulse      = err_pulse_q;
  assign burst_ok       = burst_ok_q;
  assign err_sticky     = err_sticky_q;
  assign err_cnt        = err_cnt_q;
  assign first_err_data = first_err_data_q;
  assign first_err_beat = first_err_beat_q;
  assign beat_idx       = beat_idx_q;

endmodule

// File: tb/tb_ddr2_rd_data_chk_16.sv
// tb/tb_ddr2_rd_data_chk_16.sv - self-checking bench for ddr2_rd_data_chk_16
module tb_ddr2_rd_data_chk_16;

  localparam int W      = 4;
  localparam int CNTMAX = (1 << W) - 1;

  logic          clk0 = 1'b0;
  logic          rst_n = 1'b0;
  logic          rd_data_valid = 1'b0;
  logic [31:0]   rd_data = 32'h0;
  logic          clr_err = 1'b0;
  logic          err_pulse;
  logic          err_sticky;
  logic [W-1:0]  err_cnt;
  logic [31:0]   first_err_data;
  logic [1:0]    first_err_beat;
  logic          burst_ok;
  logic [1:0]    beat_idx;

  int total = 0;
  int bad   = 0;

  int          m_idx;
  bit          m_sticky;
  int          m_cnt;
  logic [31:0] m_first_data;
  int          m_first_beat;
  bit          m_bad;
  bit          e_pulse;
  bit          e_ok;
  int          pulse_seen;
  int          ok_seen;

  ddr2_rd_data_chk_16 #(.ERR_CNT_W(W)) dut (
    .clk0           (clk0),
    .rst_n          (rst_n),
    .rd_data_valid  (rd_data_valid),
    .rd_data        (rd_data),
    .clr_err        (clr_err),
    .err_pulse      (err_pulse),
    .err_sticky     (err_sticky),
    .err_cnt        (err_cnt),
    .first_err_data (first_err_data),
    .first_err_beat (first_err_beat),
    .burst_ok       (burst_ok),
    .beat_idx       (beat_idx)
  );

  always #5 clk0 = ~clk0;

  function automatic logic [31:0] expw(input int idx);
    logic [15:0] pats [4];
    pats[0] = 16'hFFFF;
    pats[1] = 16'hAAAA;
    pats[2] = 16'h5555;
    pats[3] = 16'h9999;
    return {pats[idx % 4], ~pats[idx % 4]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_idx = 0; m_sticky = 0; m_cnt = 0; m_first_data = 32'h0;
    m_first_beat = 0; m_bad = 0; e_pulse = 0; e_ok = 0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".err_pulse"},  32'(err_pulse),      32'(e_pulse));
    check({tag, ".burst_ok"},   32'(burst_ok),       32'(e_ok));
    check({tag, ".err_sticky"}, 32'(err_sticky),     32'(m_sticky));
    check({tag, ".err_cnt"},    32'(err_cnt),        32'(m_cnt));
    check({tag, ".first_data"}, first_err_data,      m_first_data);
    check({tag, ".first_beat"}, 32'(first_err_beat), 32'(m_first_beat));
    check({tag, ".beat_idx"},   32'(beat_idx),       32'(m_idx));
  endtask

  // One clock: drive inputs, advance the reference model, sample after the edge.
  task automatic step(input string tag, input bit v, input logic [31:0] d, input bit clr);
    bit mis;
    rd_data_valid = v;
    rd_data       = d;
    clr_err       = clr;
    mis     = v && (d != expw(m_idx));
    e_pulse = mis;
    e_ok    = v && (m_idx == 3) && !mis && !(m_bad && !clr);
    if (clr) begin
      m_sticky = 0; m_cnt = 0; m_first_data = 32'h0; m_first_beat = 0; m_bad = 0;
    end
    if (mis) begin
      if (!m_sticky) begin
        m_first_data = d;
        m_first_beat = m_idx;
      end
      m_sticky = 1;
      m_cnt = (m_cnt < CNTMAX) ? m_cnt + 1 : CNTMAX;
    end
    if (v) begin
      if (m_idx == 3) m_bad = 0;
      else if (mis) m_bad = 1;
      m_idx = (m_idx + 1) % 4;
    end
    @(posedge clk0);
    #1;
    if (err_pulse) pulse_seen++;
    if (burst_ok) ok_seen++;
    check_all(tag);
    rd_data_valid = 1'b0;
    clr_err       = 1'b0;
  endtask

  task automatic good_beat(input string tag);
    step(tag, 1'b1, expw(m_idx), 1'b0);
  endtask

  task automatic bad_beat(input string tag, input bit clr);
    step(tag, 1'b1, expw(m_idx) ^ (32'h1 << $urandom_range(31, 0)), clr);
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk0);
    #1;
    check_all("reset");
    rst_n = 1'b1;

    // clean back-to-back burst
    pulse_seen = 0; ok_seen = 0;
    for (int i = 0; i < 4; i++) good_beat("clean");
    check("clean.ok_count", 32'(ok_seen), 32'd1);
    check("clean.pulse_count", 32'(pulse_seen), 32'd0);

    // same burst with random idle gaps
    ok_seen = 0;
    for (int i = 0; i < 4; i++) begin
      int gaps = $urandom_range(3, 0);
      for (int g = 0; g < gaps; g++) step("gap.idle", 1'b0, $urandom, 1'b0);
      good_beat("gap.beat");
    end
    check("gap.ok_count", 32'(ok_seen), 32'd1);

    // single-bit error on beat 2
    pulse_seen = 0; ok_seen = 0;
    step("sbe.b0", 1'b1, 32'hFFFF0000, 1'b0);
    step("sbe.b1", 1'b1, 32'hAAAA5555, 1'b0);
    step("sbe.b2", 1'b1, 32'h5554AAAA, 1'b0);
    step("sbe.b3", 1'b1, 32'h99996666, 1'b0);
    check("sbe.pulse_count", 32'(pulse_seen), 32'd1);
    check("sbe.ok_count", 32'(ok_seen), 32'd0);
    check("sbe.first_data", first_err_data, 32'h5554AAAA);
    check("sbe.first_beat", 32'(first_err_beat), 32'd2);
    ok_seen = 0;
    for (int i = 0; i < 4; i++) good_beat("after_sbe");
    check("after_sbe.ok_count", 32'(ok_seen), 32'd1);

    // first-error retention: beat 0 error, then beat 3 error of next burst
    step("clr.pre", 1'b0, 32'h0, 1'b1);
    step("ret.b0", 1'b1, 32'h0BAD0000, 1'b0);
    for (int i = 0; i < 3; i++) good_beat("ret.tail");
    for (int i = 0; i < 3; i++) good_beat("ret.next");
    bad_beat("ret.b3", 1'b0);
    check("ret.first_data", first_err_data, 32'h0BAD0000);
    check("ret.cnt", 32'(err_cnt), 32'd2);

    // clr alone, then clr coincident with a mismatching beat
    step("clr.alone", 1'b0, 32'h0, 1'b1);
    check("clr.sticky", 32'(err_sticky), 32'd0);
    bad_beat("clr.coinc", 1'b1);
    check("clr.coinc_cnt", 32'(err_cnt), 32'd1);
    check("clr.coinc_sticky", 32'(err_sticky), 32'd1);

    // saturation at 15 with pulses on every bad beat
    step("sat.clr", 1'b0, 32'h0, 1'b1);
    pulse_seen = 0;
    for (int i = 0; i < 20; i++) bad_beat("sat", 1'b0);
    check("sat.pulse_count", 32'(pulse_seen), 32'd20);
    check("sat.cnt", 32'(err_cnt), 32'(CNTMAX));

    // randomized traffic with gaps, errors and occasional clears
    for (int i = 0; i < 300; i++) begin
      int r = $urandom_range(15, 0);
      bit c = ($urandom_range(31, 0) == 0);
      if (r < 4) step("rnd.idle", 1'b0, $urandom, c);
      else if (r < 6) bad_beat("rnd.bad", c);
      else step("rnd.good", 1'b1, expw(m_idx), c);
    end

    // asynchronous reset mid-burst
    step("mid.clr", 1'b0, 32'h0, 1'b1);
    good_beat("mid.b0");
    good_beat("mid.b1");
    bad_beat("mid.b2", 1'b0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("mid.async");
    #2;
    rst_n = 1'b1;
    ok_seen = 0;
    for (int i = 0; i < 4; i++) good_beat("mid.fresh");
    check("mid.ok_count", 32'(ok_seen), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
